// File: rtl/glip_traffic_core.sv
// GLIP demo stream core: registered loopback, constant/counter source, or sequence-checking sink.
// Loopback latency 1 cycle through a 2-entry skid FIFO; ready/valid drop for one cycle on any mode change.
module glip_traffic_core #(
  parameter int unsigned      WIDTH     = 16,
  parameter logic [WIDTH-1:0] CONST     = WIDTH'('habcd),
  parameter logic [WIDTH-1:0] SEQ_INIT  = '0,
  parameter int unsigned      ERRCNT_W  = 16,
  parameter int unsigned      BLINK_DIV = 50000000
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [1:0]          mode,
  input  logic                sink_stall,
  input  logic                clear,
  input  logic [WIDTH-1:0]    in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [WIDTH-1:0]    out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                transfer,
  output logic [ERRCNT_W-1:0] err_count,
  output logic                error,
  output logic                err_led
);

  localparam logic [1:0] MODE_LOOP  = 2'b00;
  localparam logic [1:0] MODE_CONST = 2'b01;
  localparam logic [1:0] MODE_CNT   = 2'b10;
  localparam logic [1:0] MODE_SINK  = 2'b11;

  localparam int unsigned      DIV_W   = $clog2(BLINK_DIV);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(BLINK_DIV - 1);

  logic             started;
  logic [1:0]       mode_q;
  logic [1:0]       occ;
  logic [WIDTH-1:0] mem0, mem1;
  logic [WIDTH-1:0] cnt;
  logic             synced;
  logic [WIDTH-1:0] exp_q;
  logic [DIV_W-1:0] div;
  logic             mode_chg, in_fire, out_fire, mismatch;

  // started gates the first cycle after reset release, when mode_q is not yet valid
  always_comb begin
    mode_chg  = started && (mode != mode_q);
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    if (started && !mode_chg) begin
      case (mode_q)
        MODE_LOOP: begin
          in_ready  = (occ != 2'd2);
          out_valid = (occ != 2'd0);
          out_data  = (occ != 2'd0) ? mem0 : '0;
        end
        MODE_CONST: begin
          out_valid = 1'b1;
          out_data  = CONST;
        end
        MODE_CNT: begin
          out_valid = 1'b1;
          out_data  = cnt;
        end
        default: in_ready = ~sink_stall;
      endcase
    end
    in_fire  = in_valid && in_ready;
    out_fire = out_valid && out_ready;
    mismatch = in_fire && (mode_q == MODE_SINK) && synced && (in_data != exp_q);
  end

  // mem0 is always the head entry; mem1 only holds data when occ == 2
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      occ  <= 2'd0;
      mem0 <= '0;
      mem1 <= '0;
    end else if (mode_chg) begin
      occ <= 2'd0;
    end else if (mode_q == MODE_LOOP) begin
      case ({in_fire, out_fire})
        2'b10: begin
          if (occ == 2'd0) mem0 <= in_data;
          else             mem1 <= in_data;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          mem0 <= mem1;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd2) begin
            mem0 <= mem1;
            mem1 <= in_data;
          end else begin
            mem0 <= in_data;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      started  <= 1'b0;
      mode_q   <= MODE_LOOP;
      transfer <= 1'b0;
      cnt      <= SEQ_INIT;
      synced   <= 1'b0;
      exp_q    <= '0;
    end else begin
      started  <= 1'b1;
      mode_q   <= mode;
      transfer <= in_fire || out_fire;
      if (mode_chg || clear) begin
        cnt    <= SEQ_INIT;
        synced <= 1'b0;
      end else begin
        if (out_fire && (mode_q == MODE_CNT)) cnt <= cnt + 1'b1;
        // a mismatching word also resyncs, so one bad word is counted once
        if (in_fire && (mode_q == MODE_SINK)) begin
          synced <= 1'b1;
          exp_q  <= in_data + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_count <= '0;
      error     <= 1'b0;
    end else if (clear) begin
      err_count <= '0;
      error     <= 1'b0;
    end else if (mismatch) begin
      error <= 1'b1;
      if (err_count != '1) err_count <= err_count + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div     <= '0;
      err_led <= 1'b0;
    end else if (clear || !error) begin
      div     <= '0;
      err_led <= 1'b0;
    end else if (div == DIV_MAX) begin
      div     <= '0;
      err_led <= ~err_led;
    end else begin
      div <= div + 1'b1;
    end
  end

endmodule

// File: tb/tb_glip_traffic_core.sv
// Bench for glip_traffic_core: scoreboard of expected out_data plus directed checks of
// handshake, checker, blink, mode-change and reset behaviour.
module tb_glip_traffic_core;

  logic        clk = 1'b0;
  logic        rstn, sink_stall, clear, in_valid, out_ready;
  logic [1:0]  mode;
  logic [15:0] in_data, out_data;
  logic        in_ready, out_valid, transfer, error, err_led;
  logic [1:0]  err_count;

  always #5 clk = ~clk;

  glip_traffic_core #(
    .WIDTH(16), .CONST(16'habcd), .SEQ_INIT(16'hfffe), .ERRCNT_W(2), .BLINK_DIV(4)
  ) dut (
    .clk(clk), .rstn(rstn), .mode(mode), .sink_stall(sink_stall), .clear(clear),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .transfer(transfer), .err_count(err_count), .error(error), .err_led(err_led)
  );

  int          n_chk = 0, n_fail = 0;
  int          pops = 0, accs = 0, xfer_cnt = 0;
  bit          in_hs, out_hs;
  logic [15:0] sbq[$];
  logic [15:0] w;
  int          acc0, pop0, popl;
  logic [15:0] sink_words [6] = '{16'd5, 16'd6, 16'd7, 16'd9, 16'd10, 16'd12};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic set_idle();
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    clear      = 1'b0;
    sink_stall = 1'b0;
  endtask

  // one clock cycle: sample handshakes mid-low-phase, run the scoreboard, check transfer after the edge
  task automatic step();
    bit f;
    #1;
    in_hs  = in_valid && in_ready;
    out_hs = out_valid && out_ready;
    f      = in_hs || out_hs;
    if (in_hs) begin
      accs++;
      if (mode == 2'b00) sbq.push_back(in_data);
    end
    if (out_hs) begin
      pops++;
      if (sbq.size() == 0) chk("sb_underflow", 1, 0);
      else                 chk("out_data", out_data, sbq.pop_front());
    end
    @(posedge clk);
    @(negedge clk);
    chk("transfer", transfer, f);
    if (transfer) xfer_cnt++;
  endtask

  initial begin
    rstn = 1'b0; mode = 2'b00; in_data = '0; set_idle();
    #2;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_transfer", transfer, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_error", error, 0);
    chk("rst_err_led", err_led, 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("rel_in_ready", in_ready, 0);
    chk("rel_out_valid", out_valid, 0);
    step();
    #1;
    chk("lb_idle_in_ready", in_ready, 1);
    chk("lb_idle_out_valid", out_valid, 0);

    // loopback throughput
    xfer_cnt = 0; pops = 0; w = 16'd1; acc0 = -1; pop0 = -1; popl = -1;
    out_ready = 1'b1;
    for (int k = 0; k < 40 && pops < 16; k++) begin
      in_valid = (w <= 16'd16);
      in_data  = w;
      step();
      if (in_hs) begin
        if (acc0 < 0) acc0 = k;
        w++;
      end
      if (out_hs) begin
        if (pop0 < 0) pop0 = k;
        popl = k;
      end
    end
    set_idle();
    chk("lb_pops", pops, 16);
    chk("lb_latency", pop0 - acc0, 1);
    chk("lb_rate", popl - pop0, 15);
    chk("lb_transfer_cycles", xfer_cnt, 17);

    // loopback backpressure
    pops = 0; accs = 0; w = 16'h21;
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_data = w;
      step();
      if (in_hs) w++;
    end
    chk("bp_accepts", accs, 2);
    #1;
    chk("bp_in_ready", in_ready, 0);
    out_ready = 1'b1;
    for (int k = 0; k < 10 && pops < 3; k++) begin
      in_valid = (w <= 16'h23);
      in_data  = w;
      step();
      if (in_hs) w++;
    end
    chk("bp_accepts_all", accs, 3);
    chk("bp_pops", pops, 3);
    set_idle();

    // counter source wrap
    mode = 2'b10;
    #1;
    chk("cnt_chg_valid", out_valid, 0);
    step();
    #1;
    chk("cnt_valid", out_valid, 1);
    pops = 0; out_ready = 1'b1;
    sbq.push_back(16'hfffe); sbq.push_back(16'hffff);
    sbq.push_back(16'h0000); sbq.push_back(16'h0001);
    repeat (4) step();
    chk("cnt_pops", pops, 4);
    chk("cnt_sb_empty", sbq.size(), 0);
    set_idle();

    // sink checker and blink
    mode = 2'b11;
    step(); step();
    foreach (sink_words[i]) begin
      in_valid = 1'b1;
      in_data  = sink_words[i];
      step();
      chk("sink_accept", in_hs, 1);
    end
    in_valid = 1'b0;
    step();
    chk("sink_err_count", err_count, 2);
    chk("sink_error", error, 1);
    chk("led_before_toggle", err_led, 0);
    step();
    chk("led_first_toggle", err_led, 1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clr_err_count", err_count, 0);
    chk("clr_error", error, 0);
    chk("clr_err_led", err_led, 0);
    in_valid = 1'b1; in_data = 16'd100; step();
    in_data = 16'd101; step();
    in_valid = 1'b0;
    chk("resync_err_count", err_count, 0);
    chk("resync_error", error, 0);

    // stall and saturation
    sink_stall = 1'b1; in_valid = 1'b1; in_data = 16'd0;
    #1;
    chk("stall_in_ready", in_ready, 0);
    step();
    chk("stall_no_accept", in_hs, 0);
    sink_stall = 1'b0; in_valid = 1'b0; clear = 1'b1;
    step();
    clear = 1'b0;
    for (int i = 0; i < 11; i++) begin
      in_valid = 1'b1;
      in_data  = (i % 2 == 1) ? 16'd5 : 16'd0;
      step();
    end
    in_valid = 1'b0;
    step();
    chk("sat_err_count", err_count, 3);
    chk("sat_error", error, 1);

    // mode change flushes the skid buffer
    mode = 2'b00;
    step(); step();
    accs = 0; in_valid = 1'b1;
    in_data = 16'h31; step();
    in_data = 16'h32; step();
    in_valid = 1'b0;
    chk("mc_accepts", accs, 2);
    #1;
    chk("mc_full_valid", out_valid, 1);
    mode = 2'b01;
    #1;
    chk("mc_chg_valid", out_valid, 0);
    step();
    sbq.delete();
    #1;
    chk("const_valid", out_valid, 1);
    chk("const_data", out_data, 16'habcd);
    pops = 0; out_ready = 1'b1;
    sbq.push_back(16'habcd);
    step();
    chk("const_pop", pops, 1);
    out_ready = 1'b0; mode = 2'b00;
    step();
    #1;
    chk("mc_flushed_valid", out_valid, 0);
    chk("mc_flushed_data", out_data, 0);

    // reset mid-stream
    in_valid = 1'b1; out_ready = 1'b1;
    in_data = 16'h41; step();
    in_data = 16'h42; step();
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_transfer", transfer, 0);
    chk("mid_rst_err_count", err_count, 0);
    chk("mid_rst_error", error, 0);
    chk("mid_rst_err_led", err_led, 0);
    set_idle();
    sbq.delete();
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("post_rst_out_valid", out_valid, 0);
    chk("post_rst_in_ready", in_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
